systolic_mm_engine: RTL and testbench

- Parametrised output-stationary N x N systolic matrix-multiply engine. Computes C[i][j] = sum over k of A[i][k]*B[k][j] for a runtime inner dimension k_len.
- Holds on-chip A/B operand buffers, an operand skew network, valid-gated PEs, a start/busy/done sequencer and a registered result read port.
- Sits between the host-side load logic and the result memory; successor to the fixed 4x4, 16/32-bit array with its instruction-driven controller.

---
 rtl/systolic_mm_engine.sv | 217 +++++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_engine.sv
// Output-stationary N x N systolic matrix-multiply engine with on-chip A/B operand buffers,
// skewed operand feed, valid-gated PEs, start/busy/done sequencer and registered result port.
module systolic_mm_engine #(
    parameter int N    = 4,
    parameter int DW   = 16,
    parameter int AW   = 32,
    parameter int KMAX = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a_wr_en,
    input  logic [$clog2(N)-1:0]      a_wr_row,
    input  logic [$clog2(KMAX)-1:0]   a_wr_k,
    input  logic [DW-1:0]             a_wr_data,
    input  logic                      b_wr_en,
    input  logic [$clog2(N)-1:0]      b_wr_col,
    input  logic [$clog2(KMAX)-1:0]   b_wr_k,
    input  logic [DW-1:0]             b_wr_data,
    input  logic [$clog2(KMAX):0]     k_len,
    input  logic                      signed_mode,
    input  logic                      acc_mode,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic                      rd_en,
    input  logic [$clog2(N*N)-1:0]    rd_addr,
    output logic [AW-1:0]             rd_data,
    output logic                      rd_valid
);
    localparam int KW  = $clog2(KMAX);
    localparam int DCW = $clog2(2*N);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t           state, state_nx;
    logic [KW:0]      k_len_q, k_cnt;
    logic [DCW-1:0]   d_cnt;
    logic             signed_q, acc_mode_q;
    logic             clr, feed, wr_ok;

    logic [DW-1:0]    a_buf [N][KMAX];
    logic [DW-1:0]    b_buf [N][KMAX];

    logic [DW-1:0]    a_sk [N];
    logic [DW-1:0]    b_sk [N];
    logic             a_sk_v [N];
    logic             b_sk_v [N];

    logic [DW-1:0]    pe_a [N][N];
    logic [DW-1:0]    pe_b [N][N];
    logic             pe_va [N][N];
    logic             pe_vb [N][N];
    logic [AW-1:0]    acc_flat [N*N];

    // Operand buffers are deliberately not reset so loaded data survives a reset.
    always_ff @(posedge clk) begin
        if (a_wr_en && wr_ok)
            a_buf[a_wr_row][a_wr_k] <= a_wr_data;
        if (b_wr_en && wr_ok)
            b_buf[b_wr_col][b_wr_k] <= b_wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CLEAR;
            CLEAR:   state_nx = (k_len_q == '0) ? DRAIN : FEED;
            FEED:    if (k_cnt == k_len_q - (KW+1)'(1)) state_nx = DRAIN;
            DRAIN:   if (d_cnt == DCW'(2*N-1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        clr   = (state == CLEAR);
        feed  = (state == FEED);
        wr_ok = (state == IDLE) || (state == DONE);
        busy  = (state != IDLE);
        done  = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_len_q    <= '0;
            signed_q   <= 1'b0;
            acc_mode_q <= 1'b0;
            k_cnt      <= '0;
            d_cnt      <= '0;
        end else begin
            if (state == IDLE && start) begin
                k_len_q    <= k_len;
                signed_q   <= signed_mode;
                acc_mode_q <= acc_mode;
            end
            if (clr)
                k_cnt <= '0;
            else if (feed)
                k_cnt <= k_cnt + (KW+1)'(1);
            d_cnt <= (state == DRAIN) ? d_cnt + DCW'(1) : '0;
        end
    end

    // Stage 0 is the registered buffer read; row/column i then sees i extra delay stages.
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DW-1:0] a_sh [0:i];
        logic [DW-1:0] b_sh [0:i];
        logic          a_v  [0:i];
        logic          b_v  [0:i];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst || clr) begin
                for (int d = 0; d <= i; d++) begin
                    a_sh[d] <= '0;
                    b_sh[d] <= '0;
                    a_v[d]  <= 1'b0;
                    b_v[d]  <= 1'b0;
                end
            end else begin
                a_sh[0] <= a_buf[i][k_cnt[KW-1:0]];
                b_sh[0] <= b_buf[i][k_cnt[KW-1:0]];
                a_v[0]  <= feed;
                b_v[0]  <= feed;
                for (int d = 1; d <= i; d++) begin
                    a_sh[d] <= a_sh[d-1];
                    b_sh[d] <= b_sh[d-1];
                    a_v[d]  <= a_v[d-1];
                    b_v[d]  <= b_v[d-1];
                end
            end
        end

        assign a_sk[i]   = a_sh[i];
        assign b_sk[i]   = b_sh[i];
        assign a_sk_v[i] = a_v[i];
        assign b_sk_v[i] = b_v[i];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_pe
            logic [DW-1:0] a_in, b_in, a_q, b_q;
            logic          va_in, vb_in, va_q, vb_q;
            logic [AW-1:0] a_ext, b_ext, prod, acc_q;

            if (j == 0) begin : g_ain
                assign a_in  = a_sk[i];
                assign va_in = a_sk_v[i];
            end else begin : g_ain
                assign a_in  = pe_a[i][j-1];
                assign va_in = pe_va[i][j-1];
            end

            if (i == 0) begin : g_bin
                assign b_in  = b_sk[j];
                assign vb_in = b_sk_v[j];
            end else begin : g_bin
                assign b_in  = pe_b[i-1][j];
                assign vb_in = pe_vb[i-1][j];
            end

            // Extending both operands to AW first makes the AW-bit product equal the
            // sign- or zero-extended full product, wrapping modulo 2^AW.
            always_comb begin
                a_ext = signed_q ? {{(AW-DW){a_in[DW-1]}}, a_in} : {{(AW-DW){1'b0}}, a_in};
                b_ext = signed_q ? {{(AW-DW){b_in[DW-1]}}, b_in} : {{(AW-DW){1'b0}}, b_in};
                prod  = a_ext * b_ext;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    va_q  <= 1'b0;
                    vb_q  <= 1'b0;
                    acc_q <= '0;
                end else if (clr) begin
                    va_q <= 1'b0;
                    vb_q <= 1'b0;
                    if (!acc_mode_q)
                        acc_q <= '0;
                end else begin
                    a_q  <= a_in;
                    b_q  <= b_in;
                    va_q <= va_in;
                    vb_q <= vb_in;
                    if (va_in && vb_in)
                        acc_q <= acc_q + prod;
                end
            end

            assign pe_a[i][j]       = a_q;
            assign pe_b[i][j]       = b_q;
            assign pe_va[i][j]      = va_q;
            assign pe_vb[i][j]      = vb_q;
            assign acc_flat[i*N+j]  = acc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= (int'(rd_addr) < N*N) ? acc_flat[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Self-checking bench for systolic_mm_engine: a reference model fills a scoreboard queue
// as reads are issued, and a monitor pops and compares whenever rd_valid is seen.
module tb_systolic_mm_engine;
    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int AW   = 32;
    localparam int KMAX = 256;
    localparam int MK   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_wr_en, b_wr_en;
    logic [1:0]    a_wr_row, b_wr_col;
    logic [7:0]    a_wr_k, b_wr_k;
    logic [DW-1:0] a_wr_data, b_wr_data;
    logic [8:0]    k_len;
    logic          signed_mode, acc_mode, start;
    logic          busy, done;
    logic          rd_en;
    logic [3:0]    rd_addr;
    logic [AW-1:0] rd_data;
    logic          rd_valid;

    int            checkCount = 0;
    int            errorCount = 0;
    logic [AW-1:0] sbQueue [$];
    logic [DW-1:0] modelA [N][MK];
    logic [DW-1:0] modelB [MK][N];
    logic [AW-1:0] modelC [N*N];

    always #5 clk = ~clk;

    systolic_mm_engine #(.N(N), .DW(DW), .AW(AW), .KMAX(KMAX)) dut (
        .clk(clk), .rst(rst),
        .a_wr_en(a_wr_en), .a_wr_row(a_wr_row), .a_wr_k(a_wr_k), .a_wr_data(a_wr_data),
        .b_wr_en(b_wr_en), .b_wr_col(b_wr_col), .b_wr_k(b_wr_k), .b_wr_data(b_wr_data),
        .k_len(k_len), .signed_mode(signed_mode), .acc_mode(acc_mode), .start(start),
        .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Every returned read must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && rd_valid) begin
            if (sbQueue.size() == 0)
                checkOutput("sb_unexpected_read", 1, 0);
            else
                checkOutput("rd_data", rd_data, sbQueue.pop_front());
        end
    end

    function automatic logic [AW-1:0] extend(input logic [DW-1:0] v, input logic s);
        return s ? {{(AW-DW){v[DW-1]}}, v} : {{(AW-DW){1'b0}}, v};
    endfunction

    // Writes A[idx][k] and B[k][idx] in the same cycle and mirrors them into the model.
    task automatic applyStimulus(input int idx, input int k, input logic [DW-1:0] aData, input logic [DW-1:0] bData);
        @(negedge clk);
        a_wr_en   = 1'b1;  a_wr_row = 2'(idx); a_wr_k = 8'(k); a_wr_data = aData;
        b_wr_en   = 1'b1;  b_wr_col = 2'(idx); b_wr_k = 8'(k); b_wr_data = bData;
        modelA[idx][k] = aData;
        modelB[k][idx] = bData;
        @(negedge clk);
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
    endtask

    task automatic computeModel(input int klen, input logic sgn, input logic accm);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (!accm) modelC[i*N+j] = '0;
                for (int k = 0; k < klen; k++)
                    modelC[i*N+j] = modelC[i*N+j] + extend(modelA[i][k], sgn) * extend(modelB[k][j], sgn);
            end
    endtask

    // n counts clock edges after the start edge; done seen at negedge n was sampled high at edge t0+n.
    task automatic runMatrix(input int klen, input logic sgn, input logic accm, input bit extraStart);
        int n, busyCnt, pulses;
        bit doneSeen;
        computeModel(klen, sgn, accm);
        @(negedge clk);
        k_len = 9'(klen); signed_mode = sgn; acc_mode = accm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1; busyCnt = 0; doneSeen = 0;
        while (!doneSeen && n <= 600) begin
            if (busy) busyCnt++;
            if (done) doneSeen = 1;
            else begin
                if (extraStart && n == 3) begin
                    start = 1'b1;
                    a_wr_en = 1'b1; a_wr_row = 2'd0; a_wr_k = 8'd0; a_wr_data = 16'h1234;
                end else begin
                    start = 1'b0;
                    a_wr_en = 1'b0;
                end
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        a_wr_en = 1'b0;
        checkOutput("done_latency", n, klen + 2*N + 2);
        checkOutput("busy_cycles", busyCnt, klen + 2*N + 2);
        @(negedge clk);
        checkOutput("after_done_busy_done", {busy, done}, 0);
        if (extraStart) begin
            pulses = 0;
            repeat (40) begin
                @(negedge clk);
                if (done || busy) pulses++;
            end
            checkOutput("ignored_start_activity", pulses, 0);
        end
    endtask

    task automatic readAll();
        for (int idx = 0; idx < N*N; idx++) begin
            @(negedge clk);
            rd_en = 1'b1; rd_addr = 4'(idx);
            sbQueue.push_back(modelC[idx]);
        end
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        checkOutput("rd_valid_idle", rd_valid, 0);
        checkOutput("rd_data_hold", rd_data, modelC[N*N-1]);
    endtask

    task automatic loadScenario1();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 4; k++)
                applyStimulus(i, k, (i == k) ? 16'd1 : 16'd0, 16'(4*k + i + 1));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        rst = 1'b0;
        a_wr_en = 0; a_wr_row = 0; a_wr_k = 0; a_wr_data = 0;
        b_wr_en = 0; b_wr_col = 0; b_wr_k = 0; b_wr_data = 0;
        k_len = 0; signed_mode = 0; acc_mode = 0; start = 0;
        rd_en = 0; rd_addr = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_rd_valid", rd_valid, 0);
        checkOutput("reset_rd_data", rd_data, 0);
        rst = 1'b1;

        $display("[TB] identity A times ramp B");
        loadScenario1();
        runMatrix(4, 1'b0, 1'b0, 1'b0);
        readAll();
        @(negedge clk);
        rd_en = 1'b1; rd_addr = 4'd5;
        sbQueue.push_back(32'd6);
        @(negedge clk);
        rd_en = 1'b0;
        checkOutput("rd_latency_valid", rd_valid, 1);

        $display("[TB] k_len=1 outer product and k_len=0");
        for (int i = 0; i < N; i++)
            applyStimulus(i, 0, 16'(i + 1), 16'(i + 2));
        runMatrix(1, 1'b0, 1'b0, 1'b0);
        readAll();
        runMatrix(0, 1'b0, 1'b0, 1'b0);
        readAll();

        $display("[TB] accumulate mode");
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 3; k++)
                applyStimulus(i, k, 16'd1, 16'd1);
        runMatrix(3, 1'b0, 1'b0, 1'b0);
        readAll();
        runMatrix(3, 1'b0, 1'b1, 1'b0);
        readAll();
        runMatrix(3, 1'b0, 1'b0, 1'b0);
        readAll();

        $display("[TB] signed and unsigned products");
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 2; k++)
                applyStimulus(i, k, 16'hFFFF, 16'hFFFE);
        runMatrix(2, 1'b1, 1'b0, 1'b0);
        readAll();
        runMatrix(2, 1'b0, 1'b0, 1'b0);
        readAll();

        $display("[TB] wrap, start and write while busy");
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 2; k++)
                applyStimulus(i, k, 16'hFFFF, 16'hFFFF);
        runMatrix(2, 1'b0, 1'b0, 1'b1);
        readAll();
        runMatrix(2, 1'b0, 1'b0, 1'b0);
        readAll();

        $display("[TB] reset during feed");
        loadScenario1();
        @(negedge clk);
        k_len = 9'd4; signed_mode = 1'b0; acc_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        checkOutput("abort_no_done", pulses, 0);
        for (int idx = 0; idx < N*N; idx++) modelC[idx] = '0;
        readAll();
        runMatrix(4, 1'b0, 1'b0, 1'b0);
        readAll();

        repeat (2) @(negedge clk);
        checkOutput("sb_drain", sbQueue.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
